// File: rtl/reset_sequencer.sv
// Timed system-reset sequencer: turns a long-press request (or power-on) into a
// fixed-length sys_rst window, an init_start/init_done handshake and a release wait.
module reset_sequencer #(
    parameter int TICK_CYCLES       = 50000000,
    parameter int RST_HOLD_TICKS    = 2,
    parameter int ACK_TIMEOUT_TICKS = 3,
    parameter int COUNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rst_req,
    input  logic               init_done,
    output logic               sys_rst,
    output logic               init_start,
    output logic               busy,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] rst_count
);

    localparam int CYC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MAX_TICKS = (RST_HOLD_TICKS > ACK_TIMEOUT_TICKS) ? RST_HOLD_TICKS : ACK_TIMEOUT_TICKS;
    localparam int TCK_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TICK_CYCLES - 1);
    localparam logic [TCK_W-1:0] HOLD_LAST = TCK_W'(RST_HOLD_TICKS - 1);
    localparam logic [TCK_W-1:0] ACK_LAST  = TCK_W'(ACK_TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_INIT, S_RELEASE} state_e;

    state_e             state_q, state_d;
    logic               req_s1_q, req_s2_q, req_prev_q;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [TCK_W-1:0]   tck_q, tck_d;
    logic               pwr_on_q, pwr_on_d;
    logic               sys_rst_q, sys_rst_d;
    logic               init_start_q, init_start_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [COUNT_W-1:0] rst_count_q, rst_count_d;
    logic               req_rise;
    logic               tick;

    assign req_rise = req_s2_q & ~req_prev_q;
    assign tick     = ((state_q == S_ASSERT) || (state_q == S_INIT)) && (cyc_q == CYC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ASSERT;
            req_s1_q      <= 1'b0;
            req_s2_q      <= 1'b0;
            req_prev_q    <= 1'b0;
            cyc_q         <= '0;
            tck_q         <= '0;
            pwr_on_q      <= 1'b1;
            sys_rst_q     <= 1'b1;
            init_start_q  <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            rst_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            req_s1_q      <= rst_req;
            req_s2_q      <= req_s1_q;
            // Tracking the synchronised level in every state keeps a held request
            // from looking like a fresh edge once RELEASE hands back to IDLE.
            req_prev_q    <= req_s2_q;
            cyc_q         <= cyc_d;
            tck_q         <= tck_d;
            pwr_on_q      <= pwr_on_d;
            sys_rst_q     <= sys_rst_d;
            init_start_q  <= init_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            rst_count_q   <= rst_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req_rise) state_d = S_ASSERT;
            S_ASSERT:  if (tick && (tck_q == HOLD_LAST)) state_d = S_INIT;
            S_INIT:    if (init_done || (tick && (tck_q == ACK_LAST))) state_d = S_RELEASE;
            S_RELEASE: if (!req_s2_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Timers restart on every state entry so each timed state has an exact length.
        cyc_d = cyc_q;
        tck_d = tck_q;
        if (state_d != state_q) begin
            cyc_d = '0;
            tck_d = '0;
        end else if ((state_q == S_ASSERT) || (state_q == S_INIT)) begin
            if (tick) begin
                cyc_d = '0;
                tck_d = tck_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_comb begin
        sys_rst_d     = (state_d == S_ASSERT);
        init_start_d  = (state_d == S_INIT) && (state_q != S_INIT);
        busy_d        = (state_d != S_IDLE);
        timeout_err_d = timeout_err_q;
        rst_count_d   = rst_count_q;
        pwr_on_d      = pwr_on_q;
        if ((state_q == S_INIT) && (state_d == S_RELEASE)) begin
            timeout_err_d = ~init_done;
            if (!pwr_on_q && (rst_count_q != '1)) rst_count_d = rst_count_q + 1'b1;
            pwr_on_d = 1'b0;
        end
    end

    assign sys_rst     = sys_rst_q;
    assign init_start  = init_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign rst_count   = rst_count_q;

endmodule
